uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 217, i_Clk cycles per serial bit period (legal range 4..65535).
REQ-002 SHALL have port: i_Clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_RX_Serial  input  1  asynchronous serial line, idle high, 8N1 framing (8E1 with parity).
REQ-005 SHALL have port: o_RX_Byte  output  8  last correctly received byte; held until the next good byte.
REQ-006 SHALL have port: o_RX_DV  output  1  one-cycle pulse; o_RX_Byte is valid and newly updated on that cycle.
REQ-007 SHALL have port: o_RX_Busy  output  1  high from start-bit detection until return to IDLE.
REQ-008 SHALL have port: o_Frame_Err  output  1  one-cycle pulse when the sampled stop bit is low.
REQ-009 SHALL have port: o_Parity_Err  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

Function
REQ-010 SHALL pass i_RX_Serial through a 2-flop synchronizer, reset to 1; all decisions use the synchronized value.
REQ-011 SHALL implement states IDLE, START_BIT, DATA_BITS, PARITY_BIT (macro only), STOP_BIT, CLEANUP, WAIT_HIGH.
REQ-012 IDLE SHALL clear the bit counter and bit index; on a synchronized low it SHALL enter START_BIT and assert o_RX_Busy.
REQ-013 START_BIT SHALL re-sample at count (CLKS_PER_BIT-1)/2 (integer division); low -> DATA_BITS with count 0; high -> IDLE (glitch rejected, no error pulse).
REQ-014 DATA_BITS SHALL sample once per bit at count CLKS_PER_BIT-1, giving mid-bit sampling; it SHALL store bits LSB first into a shift register, index 0..7.
REQ-015 After index 7 it SHALL enter PARITY_BIT when parity is compiled in, else STOP_BIT.
REQ-016 STOP_BIT SHALL sample at count CLKS_PER_BIT-1.
REQ-017 On a high stop-bit sample, the block SHALL update o_RX_Byte and pulse o_RX_DV on the same cycle it enters CLEANUP, unless a parity error is pending.
REQ-018 On a low stop-bit sample, the block SHALL pulse o_Frame_Err, leave o_RX_Byte unchanged, not pulse o_RX_DV, and enter WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL hold until the synchronized line is high, then enter IDLE, so that a break condition is not treated as a stream of start bits.
REQ-020 CLEANUP SHALL last exactly one cycle, deassert o_RX_Busy and enter IDLE; the next start bit is accepted on the following cycle.
REQ-021 At most one of o_RX_DV, o_Frame_Err and o_Parity_Err SHALL pulse per frame; o_Frame_Err takes priority over o_Parity_Err.
REQ-022 The bit counter SHALL be wide enough to hold CLKS_PER_BIT-1 and SHALL never wrap within a bit period.
REQ-023 An undefined state encoding SHALL return to IDLE on the next cycle.

Reset
REQ-024 Asserting i_Rst_L low SHALL immediately force: state IDLE, counter 0, index 0, o_RX_Byte 0x00, all pulse outputs 0, o_RX_Busy 0, synchronizer flops 1.
REQ-025 Reset mid-frame SHALL discard the partial byte; after release, the block SHALL wait for a fresh high-to-low transition.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: PARITY_BIT state is present and samples one even-parity bit at count CLKS_PER_BIT-1.
REQ-027 With UART_RX_PARITY_EN defined, a mismatch SHALL produce an o_Parity_Err pulse at stop-bit evaluation, with no o_RX_DV pulse and o_RX_Byte unchanged.
REQ-028 Macro UART_RX_PARITY_EN undefined: no PARITY_BIT state, 8N1 framing, o_Parity_Err tied 0.

Structure
REQ-029 Package uart_pkg SHALL hold the state encodings and the default CLKS_PER_BIT constant shared by the UART transmitter and receiver.
REQ-030 The synchronizer SHALL be a sub-module uart_sync_2ff, with a reset value parameter.

Verification (CLKS_PER_BIT=8)
REQ-031 Send 0xA5 as 8N1 -> o_RX_DV pulses once, o_RX_Byte=0xA5, o_Frame_Err=0.
REQ-032 Drive a low glitch of 3 cycles -> no pulses, o_RX_Busy returns low, and a following 0x3C is received correctly.
REQ-033 Send 0x55 with a low stop bit, holding the line low for 40 cycles -> o_Frame_Err pulses once, o_RX_Byte keeps its previous value, no new frame starts before the line goes high.
REQ-034 Send back-to-back 0x00 and 0xFF with no idle gap -> two o_RX_DV pulses, with o_RX_Byte equal to 0x00 then 0xFF.
REQ-035 Assert reset during data bit 4 of 0x81, then send 0x7E -> o_RX_Byte=0x00 after reset, then exactly one o_RX_DV with 0x7E.
REQ-036 With UART_RX_PARITY_EN defined, send 0x03 with parity bit 1 -> o_Parity_Err pulses and there is no o_RX_DV; with parity bit 0 -> o_RX_DV with 0x03.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver.
//   DEFAULT_CLKS_PER_BIT : default clock cycles per serial bit period
//   uart_state_t         : receiver FSM state encodings
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY_BIT state.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 217;

  // Encodings are fixed so that the unused codes (3 without parity, and 7)
  // are caught by the FSM's recovery branch.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY_BIT = 3'd3,
`endif
    STOP_BIT   = 3'd4,
    CLEANUP    = 3'd5,
    WAIT_HIGH  = 3'd6
  } uart_state_t;

endpackage

// File: rtl/uart_sync_2ff.sv
// ---------------------------------------------------------------------------
// uart_sync_2ff
// Two-flop synchronizer that brings an asynchronous level into the i_Clk
// domain. Both flops reset to RESET_VAL.
//   i_Clk   : clock
//   i_Rst_L : asynchronous active-low reset
//   d       : asynchronous input
//   q       : synchronized output
// ---------------------------------------------------------------------------
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver, 8N1 framing (8E1 when UART_RX_PARITY_EN is defined).
// Mid-bit sampling driven by a per-bit cycle counter.
//   i_Clk        : clock, rising edge
//   i_Rst_L      : asynchronous active-low reset
//   i_RX_Serial  : serial line, idle high
//   o_RX_Byte    : last correctly received byte
//   o_RX_DV      : one-cycle pulse, o_RX_Byte newly updated
//   o_RX_Busy    : high from start-bit detection until back in IDLE
//   o_Frame_Err  : one-cycle pulse, stop bit sampled low
//   o_Parity_Err : one-cycle pulse, even-parity mismatch (0 without parity)
// Optional feature macro: UART_RX_PARITY_EN.
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV,
  output logic       o_RX_Busy,
  output logic       o_Frame_Err,
  output logic       o_Parity_Err
);

  // Counter only ever needs to reach CLKS_PER_BIT-1.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);

  logic             rx_sync;
  uart_state_t      state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       byte_q, byte_n;
  logic             dv_q, dv_n;
  logic             ferr_q, ferr_n;
  logic             busy_q, busy_n;
`ifdef UART_RX_PARITY_EN
  logic             par_pend, par_pend_n;
  logic             perr_q, perr_n;
`endif

  uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .d       (i_RX_Serial),
    .q       (rx_sync)
  );

  // Next-state and datapath logic. Error/valid pulses default low so each
  // lasts exactly one cycle; a parity error is only reported at stop-bit
  // evaluation so a framing error can take priority over it.
  always_comb begin
    state_n = state;
    count_n = count;
    idx_n   = idx;
    shift_n = shift;
    byte_n  = byte_q;
    dv_n    = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_pend_n = par_pend;
    perr_n     = 1'b0;
`endif
    case (state)
      IDLE: begin
        count_n = '0;
        idx_n   = '0;
`ifdef UART_RX_PARITY_EN
        par_pend_n = 1'b0;
`endif
        if (!rx_sync) state_n = START_BIT;
      end
      START_BIT: begin
        if (count == HALF_CNT) begin
          count_n = '0;
          state_n = rx_sync ? IDLE : DATA_BITS;
        end else begin
          count_n = count + 1'b1;
        end
      end
      DATA_BITS: begin
        if (count != LAST_CNT) begin
          count_n = count + 1'b1;
        end else begin
          count_n      = '0;
          shift_n[idx] = rx_sync;
          if (idx == 3'd7) begin
            idx_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n = PARITY_BIT;
`else
            state_n = STOP_BIT;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY_BIT: begin
        if (count != LAST_CNT) begin
          count_n = count + 1'b1;
        end else begin
          count_n    = '0;
          par_pend_n = (rx_sync != ^shift);
          state_n    = STOP_BIT;
        end
      end
`endif
      STOP_BIT: begin
        if (count != LAST_CNT) begin
          count_n = count + 1'b1;
        end else begin
          count_n = '0;
          if (!rx_sync) begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          end else if (par_pend) begin
            perr_n  = 1'b1;
            state_n = CLEANUP;
`endif
          end else begin
            byte_n  = shift;
            dv_n    = 1'b1;
            state_n = CLEANUP;
          end
        end
      end
      CLEANUP: begin
        state_n = IDLE;
      end
      WAIT_HIGH: begin
        count_n = '0;
        if (rx_sync) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
        idx_n   = '0;
      end
    endcase
    busy_n = !((state_n == IDLE) || (state_n == CLEANUP));
  end

  // State and datapath registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state  <= IDLE;
      count  <= '0;
      idx    <= '0;
      shift  <= '0;
      byte_q <= '0;
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      count  <= count_n;
      idx    <= idx_n;
      shift  <= shift_n;
      byte_q <= byte_n;
      dv_q   <= dv_n;
      ferr_q <= ferr_n;
      busy_q <= busy_n;
`ifdef UART_RX_PARITY_EN
      par_pend <= par_pend_n;
      perr_q   <= perr_n;
`endif
    end
  end

  assign o_RX_Byte   = byte_q;
  assign o_RX_DV     = dv_q;
  assign o_Frame_Err = ferr_q;
  assign o_RX_Busy   = busy_q;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = perr_q;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx at CLKS_PER_BIT=8. Stimulus pushes the
// expected pulse (kind + byte) into a queue; a monitor pops on every
// DV / frame-error / parity-error pulse and compares.
// Optional feature macro: UART_RX_PARITY_EN adds parity frames.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB     = 8;
  localparam int KIND_DV = 0;
  localparam int KIND_FE = 1;
  localparam int KIND_PE = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_l = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_dv, rx_busy, frame_err, parity_err;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_l),
    .i_RX_Serial  (rx),
    .o_RX_Byte    (rx_byte),
    .o_RX_DV      (rx_dv),
    .o_RX_Busy    (rx_busy),
    .o_Frame_Err  (frame_err),
    .o_Parity_Err (parity_err)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check funnels through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold the line at a level for n clock cycles, changing on negedges.
  task automatic driveBit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  // Send one frame and record the pulse it must produce.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_val, input int kind);
    exp_t e;
    e.kind = kind;
    e.data = (kind == KIND_DV) ? data : last_good;
    sb.push_back(e);
    if (kind == KIND_DV) last_good = data;
    driveBit(1'b0, CPB);
    for (int i = 0; i < 8; i++) driveBit(data[i], CPB);
`ifdef UART_RX_PARITY_EN
    driveBit(^data, CPB);
`endif
    driveBit(stop_val, CPB);
  endtask

`ifdef UART_RX_PARITY_EN
  // Frame with inverted (wrong) even-parity bit.
  task automatic sendBadParity(input logic [7:0] data);
    exp_t e;
    e.kind = KIND_PE;
    e.data = last_good;
    sb.push_back(e);
    driveBit(1'b0, CPB);
    for (int i = 0; i < 8; i++) driveBit(data[i], CPB);
    driveBit(~(^data), CPB);
    driveBit(1'b1, CPB);
  endtask
`endif

  task automatic waitDrain(input string name, input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, sb.size(), 0);
  endtask

  // Monitor: compare every output pulse against the scoreboard head.
  initial begin : monitor
    exp_t e;
    int   act_kind;
    forever begin
      @(negedge clk);
      if (rst_l && (rx_dv || frame_err || parity_err)) begin
        checkOutput("one_pulse", $countones({rx_dv, frame_err, parity_err}), 1);
        act_kind = rx_dv ? KIND_DV : (frame_err ? KIND_FE : KIND_PE);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pulse: got kind %0d byte 0x%0h, expected no pulse",
                   act_kind, rx_byte);
        end else begin
          e = sb.pop_front();
          checkOutput("pulse_kind", act_kind, e.kind);
          checkOutput("pulse_byte", rx_byte, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    logic [7:0] partial;
    repeat (3) @(negedge clk);
    checkOutput("reset_byte", rx_byte, 8'h00);
    checkOutput("reset_dv", rx_dv, 0);
    checkOutput("reset_busy", rx_busy, 0);
    checkOutput("reset_ferr", frame_err, 0);
    checkOutput("reset_perr", parity_err, 0);
    rst_l = 1'b1;
    driveBit(1'b1, 20);

    $display("[TB] basic 0xA5");
    applyStimulus(8'hA5, 1'b1, KIND_DV);
    driveBit(1'b1, 10);
    waitDrain("drain_a5", 40);
    checkOutput("idle_busy", rx_busy, 0);

    $display("[TB] glitch then 0x3C");
    driveBit(1'b0, 3);
    driveBit(1'b1, 20);
    checkOutput("glitch_busy", rx_busy, 0);
    checkOutput("glitch_byte", rx_byte, 8'hA5);
    applyStimulus(8'h3C, 1'b1, KIND_DV);
    driveBit(1'b1, 10);
    waitDrain("drain_3c", 40);

    $display("[TB] break on 0x55");
    applyStimulus(8'h55, 1'b0, KIND_FE);
    driveBit(1'b0, 40 - CPB);
    checkOutput("break_busy", rx_busy, 1);
    checkOutput("break_byte", rx_byte, 8'h3C);
    driveBit(1'b1, 6);
    checkOutput("break_idle", rx_busy, 0);
    driveBit(1'b1, 10);
    waitDrain("drain_break", 40);

    $display("[TB] back-to-back 0x00 0xFF");
    applyStimulus(8'h00, 1'b1, KIND_DV);
    applyStimulus(8'hFF, 1'b1, KIND_DV);
    driveBit(1'b1, 10);
    waitDrain("drain_b2b", 40);

    $display("[TB] reset mid-frame of 0x81, then 0x7E");
    partial = 8'h81;
    driveBit(1'b0, CPB);
    for (int i = 0; i < 4; i++) driveBit(partial[i], CPB);
    driveBit(partial[4], CPB / 2);
    rst_l = 1'b0;
    #1;
    checkOutput("midreset_byte", rx_byte, 8'h00);
    checkOutput("midreset_busy", rx_busy, 0);
    last_good = 8'h00;
    rx = 1'b1;
    @(negedge clk);
    rst_l = 1'b1;
    driveBit(1'b1, 20);
    checkOutput("postreset_busy", rx_busy, 0);
    checkOutput("postreset_byte", rx_byte, 8'h00);
    applyStimulus(8'h7E, 1'b1, KIND_DV);
    driveBit(1'b1, 10);
    waitDrain("drain_7e", 40);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity 0x03");
    sendBadParity(8'h03);
    driveBit(1'b1, 10);
    waitDrain("drain_bad_par", 40);
    checkOutput("bad_par_byte", rx_byte, 8'h7E);
    applyStimulus(8'h03, 1'b1, KIND_DV);
    driveBit(1'b1, 10);
    waitDrain("drain_good_par", 40);
`endif

    driveBit(1'b1, 20);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
